// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth signed multiplier: one add/sub-and-shift step per clock,
// WIDTH steps per product, start/busy/done handshake with a held product register.
module booth_seq_mult #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH:0]   a, q, m_ext, sum, a_nxt, q_nxt;
    logic [WIDTH-1:0] m;
    logic [CNT_W-1:0] cnt;
    logic             load, last;

    // One extra accumulator bit keeps A - (-2^(WIDTH-1)) from overflowing.
    always_comb m_ext = {m[WIDTH-1], m};

    always_comb begin
        sum = a;
        case (q[1:0])
            2'b01:   sum = a + m_ext;
            2'b10:   sum = a - m_ext;
            default: sum = a;
        endcase
        a_nxt = {sum[WIDTH], sum[WIDTH:1]};
        q_nxt = {sum[0], q[WIDTH:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: if (start) begin
                load      = 1'b1;
                state_nxt = RUN;
            end
            RUN: if (cnt == LAST_CNT) begin
                last      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a       <= '0;
            q       <= '0;
            m       <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            busy <= (state_nxt == RUN);
            done <= last;
            if (load) begin
                m   <= multiplicand;
                a   <= '0;
                q   <= {multiplier, 1'b0};
                cnt <= '0;
            end else if (state == RUN) begin
                a   <= a_nxt;
                q   <= q_nxt;
                cnt <= cnt + CNT_W'(1);
            end
            // Product is taken from the final step's shifted result, not the registers.
            if (last) product <= {a_nxt[WIDTH-1:0], q_nxt[WIDTH:1]};
        end
    end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed-vector bench for booth_seq_mult: table of hand-computed products plus
// handshake, mid-run reset and hold sequences.
module tb_booth_seq_mult;

    localparam int WIDTH = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [WIDTH-1:0]  multiplicand = '0;
    logic [WIDTH-1:0]  multiplier = '0;
    logic              busy, done;
    logic [2*WIDTH-1:0] product;

    int checks = 0;
    int errors = 0;

    booth_seq_mult #(.WIDTH(WIDTH), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .start(start),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .busy(busy), .done(done), .product(product)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  m;
        logic [7:0]  q;
        logic [15:0] p;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Launch one multiply from IDLE, wait for done; returns edges from accept to done.
    task automatic run_mult(input logic [7:0] m, input logic [7:0] q, output int lat);
        @(negedge clk);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_accept", {31'b0, busy}, 32'd1);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            if (done) break;
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        vec_t vecs[$];
        int   lat;
        logic [15:0] first_p;

        vecs.push_back('{8'h03, 8'h05, 16'h000F});
        vecs.push_back('{8'hFD, 8'h05, 16'hFFF1});
        vecs.push_back('{8'h05, 8'hFD, 16'hFFF1});
        vecs.push_back('{8'hFD, 8'hFB, 16'h000F});
        vecs.push_back('{8'h00, 8'h7F, 16'h0000});
        vecs.push_back('{8'h80, 8'h80, 16'h4000});
        vecs.push_back('{8'h7F, 8'h80, 16'hC080});
        vecs.push_back('{8'h80, 8'h01, 16'hFF80});
        vecs.push_back('{8'h7F, 8'h7F, 16'h3F01});
        vecs.push_back('{8'hFF, 8'hFF, 16'h0001});
        vecs.push_back('{8'hFF, 8'h80, 16'h0080});
        vecs.push_back('{8'h80, 8'h7F, 16'hC080});
        vecs.push_back('{8'h04, 8'h04, 16'h0010});
        vecs.push_back('{8'h03, 8'h05, 16'h000F});

        // Reset state
        #2 reset = 1'b1;
        #10;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_product", {16'b0, product}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_no_done", {31'b0, done}, 32'd0);

        // Directed table
        foreach (vecs[i]) begin
            run_mult(vecs[i].m, vecs[i].q, lat);
            chk($sformatf("latency_%0d", i), lat, 32'd8);
            chk($sformatf("busy_at_done_%0d", i), {31'b0, busy}, 32'd0);
            chk($sformatf("product_%0d", i), {16'b0, product}, {16'b0, vecs[i].p});
            @(posedge clk);
            #1;
            chk($sformatf("done_pulse_%0d", i), {31'b0, done}, 32'd0);
        end

        // Hold: last vector was 3*5; idle with random operands
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            multiplicand = 8'($urandom);
            multiplier   = 8'($urandom);
            #1;
            chk("hold_product", {16'b0, product}, 32'h000F);
            chk("hold_done_busy", {30'b0, done, busy}, 32'd0);
        end

        // start pulses while busy are ignored
        @(negedge clk);
        multiplicand = 8'd2; multiplier = 8'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        begin
            int ndone = 0;
            for (int c = 1; c <= 12; c++) begin
                @(negedge clk);
                start = (c == 3 || c == 5);
                if (c == 3 || c == 5) begin multiplicand = 8'd7; multiplier = 8'd7; end
                @(posedge clk); #1;
                start = 1'b0;
                if (done) begin
                    ndone++;
                    chk("busy_ignore_latency", c, 32'd8);
                    chk("busy_ignore_product", {16'b0, product}, 32'h0006);
                end
                if (c < 8) chk("busy_ignore_busy", {31'b0, busy}, 32'd1);
            end
            chk("busy_ignore_single_done", ndone, 32'd1);
        end

        // start in done cycle -> back-to-back, second done 9 edges later
        run_mult(8'd3, 8'd5, lat);
        chk("b2b_first", {16'b0, product}, 32'h000F);
        multiplicand = 8'd7; multiplier = 8'd7; start = 1'b1;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            start = 1'b0;
            first_p = product;
            if (done) break;
        end
        chk("b2b_spacing", lat, 32'd9);
        chk("b2b_product", {16'b0, first_p}, 32'h0031);

        // Asynchronous reset mid-run
        @(negedge clk);
        multiplicand = 8'd9; multiplier = 8'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_product", {16'b0, product}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        begin
            int seen = 0;
            for (int c = 0; c < 12; c++) begin
                @(posedge clk); #1;
                if (done || busy) seen++;
            end
            chk("abort_no_done", seen, 32'd0);
        end
        run_mult(8'd4, 8'd4, lat);
        chk("after_abort_latency", lat, 32'd8);
        chk("after_abort_product", {16'b0, product}, 32'h0010);

        // Random pairs against a signed reference
        for (int r = 0; r < 150; r++) begin
            logic [7:0] rm, rq;
            logic signed [15:0] ref_p;
            rm = 8'($urandom);
            rq = 8'($urandom);
            ref_p = 16'($signed(rm) * $signed(rq));
            run_mult(rm, rq, lat);
            chk($sformatf("rand_%0h_%0h", rm, rq), {16'b0, product}, {16'b0, ref_p});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
